// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the variable-depth delay line family.
// No state and no timing; mode encoding and delay clamping only.
package shift_reg_pkg;

  typedef enum logic {
    SR_MODE_DELAY  = 1'b0,
    SR_MODE_ROTATE = 1'b1
  } sr_mode_e;

  // Map a requested delay onto the legal range 1..stage.
  function automatic int unsigned sr_clamp_dly(input int unsigned sel, input int unsigned stage);
    if (sel == 0) return 1;
    if (sel > stage) return stage;
    return sel;
  endfunction

endpackage

// File: rtl/sr_tap_mux.sv
// Selects {data, valid} of stage cur_dly-1 from flattened stage arrays.
// Purely combinational, zero latency; no flow control of its own.
module sr_tap_mux #(
  parameter int STAGE = 4,
  parameter int WIDTH = 8,
  localparam int DW = $clog2(STAGE + 1)
) (
  input  logic [STAGE*WIDTH-1:0] ffs_flat,
  input  logic [STAGE-1:0]       vld,
  input  logic [DW-1:0]          cur_dly,
  output logic [WIDTH-1:0]       tap_dat,
  output logic                   tap_vld
);

  always_comb begin
    tap_dat = '0;
    tap_vld = 1'b0;
    for (int i = 0; i < STAGE; i++) begin
      if (cur_dly == DW'(i + 1)) begin
        tap_dat = ffs_flat[i*WIDTH +: WIDTH];
        tap_vld = vld[i];
      end
    end
  end

endmodule

// File: rtl/shift_reg_vdelay.sv
// Stallable variable-depth delay line with flush, runtime tap select and rotate mode.
// Latency cur_dly advance edges; en=0 freezes all state (stall acts as backpressure).
module shift_reg_vdelay
  import shift_reg_pkg::*;
#(
  parameter int STAGE       = 4,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DLY = STAGE,
  localparam int DW = $clog2(STAGE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  sr_mode_e         mode,
  input  logic             dly_load,
  input  logic [DW-1:0]    dly_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DW-1:0]    occupancy,
  output logic [DW-1:0]    cur_dly
);

  logic [WIDTH-1:0]       ffs [STAGE];
  logic [STAGE-1:0]       vld;
  logic [STAGE*WIDTH-1:0] ffs_flat;
  logic [WIDTH-1:0]       in_dat;
  logic                   in_vld;

  for (genvar g = 0; g < STAGE; g++) begin : g_flat
    assign ffs_flat[g*WIDTH +: WIDTH] = ffs[g];
  end

  sr_tap_mux #(
    .STAGE (STAGE),
    .WIDTH (WIDTH)
  ) u_tap (
    .ffs_flat (ffs_flat),
    .vld      (vld),
    .cur_dly  (cur_dly),
    .tap_dat  (dout),
    .tap_vld  (dout_valid)
  );

  // Rotate feeds the tap back into stage 0, so bubbles recirculate unchanged.
  assign in_dat = (mode == SR_MODE_ROTATE) ? dout       : din;
  assign in_vld = (mode == SR_MODE_ROTATE) ? dout_valid : din_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGE; i++) ffs[i] <= '0;
      vld       <= '0;
      occupancy <= '0;
      cur_dly   <= DW'(DEFAULT_DLY);
    end else if (dly_load) begin
      // A new tap invalidates what is in flight; data is left in place.
      cur_dly   <= DW'(sr_clamp_dly(32'(dly_sel), STAGE));
      vld       <= '0;
      occupancy <= '0;
    end else if (flush) begin
      vld       <= '0;
      occupancy <= '0;
    end else if (en) begin
      ffs[0] <= in_dat;
      vld[0] <= in_vld;
      for (int i = 1; i < STAGE; i++) begin
        ffs[i] <= ffs[i-1];
        vld[i] <= vld[i-1];
      end
      occupancy <= occupancy + DW'(in_vld) - DW'(dout_valid);
    end
  end

endmodule

// File: tb/tb_shift_reg_vdelay.sv
// Self-checking bench for shift_reg_vdelay (STAGE=4, WIDTH=8, DEFAULT_DLY=4).
// Directed vector table, reset corners by hand, then a queue scoreboard on random traffic.
module tb_shift_reg_vdelay;
  import shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       flush;
  sr_mode_e   mode;
  logic       dly_load;
  logic [2:0] dly_sel;
  logic [7:0] din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] occupancy;
  logic [2:0] cur_dly;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       en, fl, md, ld;
    logic [2:0] sel;
    logic [7:0] din;
    logic       dv;
    logic [7:0] e_dout;
    logic       e_dv;
    logic [2:0] e_occ, e_cur;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] sb[$];

  shift_reg_vdelay #(.STAGE(4), .WIDTH(8), .DEFAULT_DLY(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .flush      (flush),
    .mode       (mode),
    .dly_load   (dly_load),
    .dly_sel    (dly_sel),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .occupancy  (occupancy),
    .cur_dly    (cur_dly)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_dout, input logic e_dv,
                         input logic [2:0] e_occ, input logic [2:0] e_cur);
    chk({tag, "_dout"}, 32'(dout), 32'(e_dout));
    chk({tag, "_dv"},   32'(dout_valid), 32'(e_dv));
    chk({tag, "_occ"},  32'(occupancy), 32'(e_occ));
    chk({tag, "_cur"},  32'(cur_dly), 32'(e_cur));
  endtask

  function automatic vec_t mk(input logic en_i, fl_i, md_i, ld_i, input logic [2:0] sel_i,
                              input logic [7:0] din_i, input logic dv_i, input logic [7:0] ed,
                              input logic edv, input logic [2:0] eocc, ecur);
    vec_t v;
    v.en = en_i; v.fl = fl_i; v.md = md_i; v.ld = ld_i; v.sel = sel_i;
    v.din = din_i; v.dv = dv_i; v.e_dout = ed; v.e_dv = edv; v.e_occ = eocc; v.e_cur = ecur;
    return v;
  endfunction

  task automatic drive(input logic en_i, fl_i, ld_i, input sr_mode_e md_i,
                       input logic [2:0] sel_i, input logic [7:0] din_i, input logic dv_i);
    en = en_i; flush = fl_i; dly_load = ld_i; mode = md_i;
    dly_sel = sel_i; din = din_i; din_valid = dv_i;
  endtask

  initial begin
    logic [7:0] exp_d;
    rst_n = 1'b0;
    drive(0, 0, 0, SR_MODE_DELAY, 3'd0, 8'h00, 0);
    #12;
    chk_all("reset", 8'h00, 0, 3'd0, 3'd4);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency, stall, depth change, rotate and conflicts on a continuous stream.
    tbl.push_back(mk(1,0,0,0,0,8'h11,1, 8'h00,0,1,4));
    tbl.push_back(mk(1,0,0,0,0,8'h22,1, 8'h00,0,2,4));
    tbl.push_back(mk(1,0,0,0,0,8'h33,1, 8'h00,0,3,4));
    tbl.push_back(mk(1,0,0,0,0,8'h44,1, 8'h11,1,4,4));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,8'h99,1, 8'h11,1,4,4));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'h22,1,3,4));
    tbl.push_back(mk(1,0,0,1,2,8'h77,1, 8'h44,0,0,2));
    tbl.push_back(mk(1,0,0,0,0,8'hAA,1, 8'h00,0,1,2));
    tbl.push_back(mk(1,0,0,0,0,8'hBB,0, 8'hAA,1,1,2));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'hBB,0,0,2));
    tbl.push_back(mk(1,0,0,1,0,8'h00,0, 8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,1,7,8'h00,0, 8'h00,0,0,4));
    tbl.push_back(mk(0,0,0,1,3,8'h00,0, 8'hAA,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'hA1,1, 8'hBB,0,1,3));
    tbl.push_back(mk(1,0,0,0,0,8'hA2,1, 8'h00,0,2,3));
    tbl.push_back(mk(1,0,0,0,0,8'hA3,1, 8'hA1,1,3,3));
    tbl.push_back(mk(1,0,1,0,0,8'hFF,1, 8'hA2,1,3,3));
    tbl.push_back(mk(1,0,1,0,0,8'hFF,1, 8'hA3,1,3,3));
    tbl.push_back(mk(1,0,1,0,0,8'hFF,1, 8'hA1,1,3,3));
    tbl.push_back(mk(1,0,1,0,0,8'hFF,1, 8'hA2,1,3,3));
    tbl.push_back(mk(1,0,1,0,0,8'hFF,1, 8'hA3,1,3,3));
    tbl.push_back(mk(0,0,1,0,0,8'hFF,1, 8'hA3,1,3,3));
    tbl.push_back(mk(1,1,0,0,0,8'h55,1, 8'hA3,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'hA1,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'hA2,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'h00,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'h00,0, 8'h00,0,0,3));
    tbl.push_back(mk(1,0,0,0,0,8'h66,1, 8'h00,0,1,3));
    tbl.push_back(mk(1,1,0,1,2,8'h00,0, 8'h00,0,0,2));

    foreach (tbl[k]) begin
      drive(tbl[k].en, tbl[k].fl, tbl[k].ld, sr_mode_e'(tbl[k].md),
            tbl[k].sel, tbl[k].din, tbl[k].dv);
      step();
      chk_all($sformatf("v%0d", k), tbl[k].e_dout, tbl[k].e_dv, tbl[k].e_occ, tbl[k].e_cur);
    end

    // Asynchronous reset while streaming, then cold-start latency.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, SR_MODE_DELAY, 3'd0, 8'h30 + 8'(i), 1);
      step();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 8'h00, 0, 3'd0, 3'd4);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, SR_MODE_DELAY, 3'd0, 8'h12, 1);
    step();
    chk_all("postrst1", 8'h00, 0, 3'd1, 3'd4);
    drive(1, 0, 0, SR_MODE_DELAY, 3'd0, 8'h00, 0);
    for (int i = 0; i < 3; i++) step();
    chk_all("postrst4", 8'h12, 1, 3'd1, 3'd4);

    // Random stalls and bubbles at every legal depth, checked through a scoreboard.
    for (int d = 1; d <= 4; d++) begin
      drive(1, 0, 1, SR_MODE_DELAY, 3'(d), 8'h00, 0);
      step();
      sb.delete();
      chk($sformatf("sb_load%0d_cur", d), 32'(cur_dly), d);
      for (int c = 0; c < 150 + 8; c++) begin
        if (c < 150)
          drive($urandom_range(0, 3) != 0, 0, 0, SR_MODE_DELAY, 3'd0,
                8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
        else
          drive(1, 0, 0, SR_MODE_DELAY, 3'd0, 8'h00, 0);
        if (en && din_valid) sb.push_back(din);
        step();
        if (en) begin
          chk($sformatf("sb_d%0d_c%0d_occ", d, c), 32'(occupancy), sb.size());
          if (dout_valid) begin
            exp_d = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
            chk($sformatf("sb_d%0d_c%0d_dout", d, c), 32'(dout), 32'(exp_d));
          end
        end
      end
      chk($sformatf("sb_d%0d_drained", d), sb.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_reg_vdelay.md
Name: shift_reg_vdelay

Overview:
Parametrised successor to the team's fixed-depth shift register. It is a variable-depth delay line with:
- per-stage valid tracking
- global stall (enable)
- flush
- runtime-programmable tap depth
- a rotate (recirculate) mode

It sits in datapaths that need a retimable, stallable delay or a small circular pattern buffer.

Parameters:
STAGE, 4, physical number of stages; maximum delay; must be >= 1
WIDTH, 8, data width in bits
DEFAULT_DLY, STAGE, active delay after reset; must be in 1..STAGE
DW (localparam), $clog2(STAGE+1), width of delay and occupancy fields

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance; when 0 all stages hold
flush  input  1  clear all valid bits and occupancy
mode  input  1  0 = DELAY (stage 0 loads din), 1 = ROTATE (stage 0 loads tap output)
dly_load  input  1  load a new active delay from dly_sel
dly_sel  input  DW  requested delay
din  input  WIDTH  input data
din_valid  input  1  input qualifier
dout  output  WIDTH  tap output, ffs[cur_dly-1]
dout_valid  output  1  valid bit of the tap stage
occupancy  output  DW  number of valid entries within stages 0..cur_dly-1
cur_dly  output  DW  active delay, 1..STAGE

Behaviour:
- Reset is async on rst_n low. All data stages go to 0, all valid bits to 0, occupancy 0, cur_dly = DEFAULT_DLY. Outputs therefore read dout = 0 and dout_valid = 0.
- Storage: ffs[0..STAGE-1] of WIDTH bits plus vld[0..STAGE-1].
- dout and dout_valid are a combinational mux of registered state at index cur_dly-1. There is no extra output register.
- Advance (en=1, no flush, no dly_load):
  - ffs[i] <= ffs[i-1] and vld[i] <= vld[i-1] for i = 1..STAGE-1.
  - DELAY mode: ffs[0] <= din, vld[0] <= din_valid.
  - ROTATE mode: ffs[0] <= tap data, vld[0] <= tap valid. din and din_valid are ignored.
  - All STAGE stages shift; stages beyond the tap are don't-care for outputs.
- Latency: a word sampled on an advance edge appears at dout after exactly cur_dly advance edges. Stalled cycles (en=0) do not count.
- Occupancy, updated on advance only: occupancy <= occupancy + vld_in - dout_valid.
  - vld_in is din_valid in DELAY mode and dout_valid in ROTATE mode, so occupancy is constant in ROTATE.
  - Occupancy never exceeds cur_dly.
- Priority per cycle, highest first:
  1. rst_n
  2. dly_load
  3. flush
  4. en
- dly_load:
  - cur_dly <= clamp(dly_sel): 0 maps to 1, values > STAGE map to STAGE.
  - Implies a flush: all vld cleared, occupancy 0. Data registers are not cleared.
  - No shift occurs that cycle, even if en=1.
- flush: all vld <= 0, occupancy <= 0, no shift that cycle, data registers unchanged. flush together with en=1 means flush wins and din is dropped.
- mode change:
  - Takes effect on the next advance edge; no flush.
  - Switching DELAY to ROTATE with occupancy < cur_dly recirculates the bubbles as-is.
- en=0: all state holds, and outputs are stable.
- Reset mid-stream discards contents immediately (asynchronous). The first advance after release behaves as from cold reset.

Decomposition:
- Package shift_reg_pkg:
  - typedef enum logic {SR_MODE_DELAY=1'b0, SR_MODE_ROTATE=1'b1} sr_mode_e
  - function sr_clamp_dly(sel, stage) returning the clamped delay
  - The mode port is typed sr_mode_e.
- Sub-module sr_tap_mux (parametrised on STAGE and WIDTH): selects {data, valid} at index cur_dly-1 from the flattened stage arrays. It is purely combinational and reused by the planned multi-tap variant.

Test Plan (STAGE=4, WIDTH=8, DEFAULT_DLY=4):
1. Reset: assert rst_n=0 mid-clock -> immediately dout=0x00, dout_valid=0, occupancy=0, cur_dly=4.
2. DELAY latency: en=1, din_valid=1, din=0x11,0x22,0x33,0x44 on edges 1..4 -> after edge 4 dout=0x11 with dout_valid=1 and occupancy=4; after edge 5 (din_valid=0) dout=0x22 and occupancy=3.
3. Stall: after scenario 2 edge 4, hold en=0 for 3 cycles -> dout stays 0x11 and occupancy stays 4; on resume, 0x22 appears after the first advance edge.
4. Depth change:
   - dly_load=1, dly_sel=2, en=1 while occupancy=4 -> cur_dly=2, dout_valid=0, occupancy=0, no shift.
   - Then din=0xAA -> valid at dout after 2 advance edges.
   - dly_sel=0 -> cur_dly=1; dly_sel=7 -> cur_dly=4.
5. ROTATE: cur_dly=3, load 0xA1,0xA2,0xA3, set mode=1, en=1 with din=0xFF -> dout sequence 0xA1,0xA2,0xA3,0xA1,0xA2... with dout_valid=1 and occupancy constant at 3; 0xFF never appears.
6. Conflicts:
   - flush=1 with en=1, din=0x55 -> occupancy=0, dout_valid=0, and 0x55 never emerges.
   - dly_load with flush -> cur_dly updated and all valids clear.
   - rst_n low during streaming -> all cleared, cur_dly=4.
